fp_add_scheduler: RTL and testbench
===================================

Name: fp_add_scheduler

Overview:
Shares one fp_adder instance between NREQ requesters using round-robin arbitration and per-requester valid/ready handshakes. The block registers the selected operands and rounding mode into the adder and tracks in-flight operations through ADD_LAT adder pipeline stages. Results return in issue order on a single tagged response channel with a credit-protected FIFO. A flush/halt state machine lets the FPU control logic quiesce the adder.

Parameters:
NREQ, 2, number of requesters; legal range 2..8.
RSP_DEPTH, 4, response FIFO depth; power of 2; must be >= ADD_LAT+2 for full throughput.
ADD_LAT, 0, adder latency in cycles from add_valid to add_result valid; legal range 0..4; 0 means combinational.
IDW, $clog2(NREQ), requester-id width; local and derived, not overridable.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept
req_a  in  NREQ*32  operand A; slice i belongs to requester i
req_b  in  NREQ*32  operand B
req_rmode  in  NREQ*3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
add_valid  out  1  operation presented to adder
add_a  out  32  registered operand A to adder fp_a
add_b  out  32  registered operand B to adder fp_b
add_rmode  out  3  registered rounding mode to adder r_mode
add_result  in  32  adder fp_result
add_overflow  in  1  adder overflow
add_underflow  in  1  adder underflow
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accept
rsp_id  out  IDW  originating requester
rsp_result  out  32  sum
rsp_overflow  out  1  captured overflow
rsp_underflow  out  1  captured underflow
rsp_err  out  1  request carried an illegal rmode
flush_req  in  1  pulse: stop accepting new requests and drain
resume  in  1  pulse: leave HALT
halted  out  1  adder idle and drained

Behaviour:
- Reset and control: one clock; reset is synchronous and active-high (clk, rst).
- While rst is high, every output is 0, FIFO and in-flight tracking are cleared, the RR pointer selects requester 0 first, and state is RUN. A reset mid-operation discards all in-flight results; no stale response appears afterwards.
- State machine:
  - RUN: accepting requests. flush_req moves to DRAIN.
  - DRAIN: req_ready = 0. When inflight == 0 and the FIFO is empty, move to HALT.
  - HALT: halted = 1 and req_ready = 0. resume moves to RUN.
  - flush_req in DRAIN or HALT is ignored. resume outside HALT is ignored. If flush_req and resume assert together in HALT, resume wins.
- Issue conditions: state is RUN and (inflight + fifo_count) < RSP_DEPTH. A FIFO pop in the same cycle does not free a credit that cycle.
- Arbitration:
  - At most one grant per cycle.
  - The winner is the first valid requester strictly after the last winner, wrapping around.
  - req_ready[i] = grant[i], a combinational function of req_valid; all req_ready are 0 when issue is blocked.
  - The pointer advances only on an accepted transfer (valid && ready).
- Latency:
  - Transfer at edge T registers the operands; add_valid = 1 in cycle T+1.
  - add_a, add_b and add_rmode hold their last value when add_valid = 0.
  - The result is captured at the end of cycle T+1+ADD_LAT and pushed to the FIFO.
  - Earliest rsp_valid is cycle T+2+ADD_LAT.
  - Throughput is one operation per cycle.
- Tag pipe: an ADD_LAT-deep shift register carries {valid, id, err} alongside the adder.
- Illegal rmode (101..111): the request is accepted, add_rmode is forced to 000, and rsp_err = 1 on that response.
- Response channel:
  - Responses leave in issue order; FIFO head drives all rsp_* outputs.
  - Pop on rsp_valid && rsp_ready. rsp_* hold stable while rsp_valid && !rsp_ready.
  - Push and pop in the same cycle are legal. The credit rule guarantees no push ever occurs while the FIFO is full.
- inflight counts accepted operations not yet pushed; its width is $clog2(RSP_DEPTH+1).

Optional Feature:
FP_ADD_SCHED_PERF_EN:
- Defined: adds outputs perf_issued (32) and perf_stall (32).
  - perf_issued increments on each accepted transfer.
  - perf_stall increments each cycle in which any req_valid is high in RUN but no grant is given because of credits.
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. ADD_LAT=0; requester 0 sends a=3F800000, b=3F800000, rmode=000 -> add_valid one cycle later; rsp_valid two cycles after the handshake with rsp_id=0, rsp_result=40000000, flags 0.
2. Requesters 0 and 1 hold valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; one issue per cycle; rsp_id sequence matches the grant order.
3. RSP_DEPTH=4, rsp_ready=0, both requesters valid -> exactly 4 transfers, then all req_ready=0; raise rsp_ready -> 4 in-order responses, then issue resumes.
4. ADD_LAT=2, flush_req with 2 operations in flight -> no further req_ready; halted rises the cycle after the last response pops; resume -> requests accepted next cycle.
5. Requester 1 sends rmode=110 -> add_rmode=000; rsp_err=1 and rsp_id=1.
6. rst asserted for 1 cycle with 3 operations in flight and 1 queued -> all outputs 0 during reset; no rsp_valid afterwards until new requests; requester 0 wins first.

Source files
------------

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one fp_adder between NREQ requesters, with in-order tagged responses.
// Define FP_ADD_SCHED_PERF_EN to add the perf_issued / perf_stall counters.
module fp_add_scheduler #(
    parameter int NREQ      = 2,
    parameter int RSP_DEPTH = 4,
    parameter int ADD_LAT   = 0,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*3-1:0]    req_rmode,
    output logic                 add_valid,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic [2:0]           add_rmode,
    input  logic [31:0]          add_result,
    input  logic                 add_overflow,
    input  logic                 add_underflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_overflow,
    output logic                 rsp_underflow,
    output logic                 rsp_err,
    input  logic                 flush_req,
    input  logic                 resume,
    output logic                 halted
`ifdef FP_ADD_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_issued,
    output logic [31:0]          perf_stall
`endif
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int AW = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           err;
        logic           ovf;
        logic           unf;
        logic [31:0]    result;
    } rsp_t;

    state_t             state;
    logic               halted_q;
    logic [IDW-1:0]     last_id;
    logic [CW-1:0]      inflight, inflight_nxt;
    logic [CW-1:0]      fifo_count, fifo_count_nxt;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    rsp_t               mem [RSP_DEPTH];
    rsp_t               head;

    logic [ADD_LAT:0]   tag_v;
    logic [ADD_LAT:0]   tag_err;
    logic [IDW-1:0]     tag_id [ADD_LAT+1];

    logic [31:0]        add_a_q, add_b_q;
    logic [2:0]         add_rmode_q;

    logic               credit_ok, can_issue, accept, push, pop, found;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     win_id;
    logic [2:0]         win_rmode;
    logic               win_err;
    int                 idx;

    // Credits cover both ops still in the adder and results waiting in the FIFO.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW+1)'(RSP_DEPTH);
    assign can_issue = !rst && (state == RUN) && credit_ok;

    always_comb begin
        grant  = '0;
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_id) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                win_id = IDW'(idx);
            end
        end
        if (found && can_issue) grant[win_id] = 1'b1;
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign win_rmode = req_rmode[win_id*3 +: 3];
    assign win_err   = (win_rmode > 3'd4);

    assign push           = tag_v[ADD_LAT];
    assign rsp_valid      = !rst && (fifo_count != '0);
    assign pop            = rsp_valid && rsp_ready;
    assign inflight_nxt   = inflight + CW'(accept) - CW'(push);
    assign fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            halted_q    <= 1'b0;
            last_id     <= IDW'(NREQ - 1);
            inflight    <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_v       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_rmode_q <= '0;
        end else begin
            tag_v[0] <= accept;
            for (int k = 1; k <= ADD_LAT; k++) tag_v[k] <= tag_v[k-1];
            if (accept) begin
                last_id     <= win_id;
                add_a_q     <= req_a[win_id*32 +: 32];
                add_b_q     <= req_b[win_id*32 +: 32];
                add_rmode_q <= win_err ? 3'b000 : win_rmode;
            end
            inflight   <= inflight_nxt;
            fifo_count <= fifo_count_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            // Drain completes on the edge that retires the last outstanding op.
            case (state)
                RUN:   if (flush_req) state <= DRAIN;
                DRAIN: if (inflight_nxt == '0 && fifo_count_nxt == '0) begin
                    state    <= HALT;
                    halted_q <= 1'b1;
                end
                HALT:  if (resume) begin
                    state    <= RUN;
                    halted_q <= 1'b0;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0]  <= win_id;
        tag_err[0] <= win_err;
        for (int k = 1; k <= ADD_LAT; k++) begin
            tag_id[k]  <= tag_id[k-1];
            tag_err[k] <= tag_err[k-1];
        end
        if (push) mem[wr_ptr] <= '{tag_id[ADD_LAT], tag_err[ADD_LAT], add_overflow, add_underflow, add_result};
    end

    assign head          = mem[rd_ptr];
    assign rsp_id        = rsp_valid ? head.id     : '0;
    assign rsp_err       = rsp_valid ? head.err    : 1'b0;
    assign rsp_overflow  = rsp_valid ? head.ovf    : 1'b0;
    assign rsp_underflow = rsp_valid ? head.unf    : 1'b0;
    assign rsp_result    = rsp_valid ? head.result : '0;

    assign add_valid = tag_v[0] && !rst;
    assign add_a     = rst ? '0 : add_a_q;
    assign add_b     = rst ? '0 : add_b_q;
    assign add_rmode = rst ? '0 : add_rmode_q;
    assign halted    = halted_q && !rst;

`ifdef FP_ADD_SCHED_PERF_EN
    logic [31:0] issued_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (accept && issued_q != 32'hFFFF_FFFF) issued_q <= issued_q + 32'd1;
            if (state == RUN && |req_valid && !credit_ok && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_issued = rst ? '0 : issued_q;
    assign perf_stall  = rst ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a transaction-level scoreboard.
module tb_fp_add_scheduler;

    localparam int NREQ      = 2;
    localparam int RSP_DEPTH = 4;
    localparam int ADD_LAT   = 2;
    localparam int IDW       = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a, req_b;
    logic [NREQ*3-1:0]    req_rmode;
    logic                 add_valid;
    logic [31:0]          add_a, add_b;
    logic [2:0]           add_rmode;
    logic [31:0]          add_result;
    logic                 add_overflow, add_underflow;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_overflow, rsp_underflow, rsp_err;
    logic                 flush_req, resume, halted;

    fp_add_scheduler #(.NREQ(NREQ), .RSP_DEPTH(RSP_DEPTH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rmode(req_rmode),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_rmode(add_rmode),
        .add_result(add_result), .add_overflow(add_overflow), .add_underflow(add_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
        .rsp_err(rsp_err), .flush_req(flush_req), .resume(resume), .halted(halted)
    );

    always #5 clk = ~clk;

    // Stand-in adder: single-precision sum via double arithmetic (normals only, truncating).
    function automatic logic [63:0] to_dbl(input logic [31:0] x);
        if (x[30:23] == 8'd0) return {x[31], 63'd0};
        return {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] from_dbl(input logic [63:0] d);
        int e;
        e = int'(d[62:52]) - 896;
        if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fake_sum(input logic [31:0] a, input logic [31:0] b);
        real s;
        s = $bitstoreal(to_dbl(a)) + $bitstoreal(to_dbl(b));
        return from_dbl($realtobits(s));
    endfunction

    function automatic logic [33:0] fake_add(input logic [31:0] a, input logic [31:0] b);
        return {a[2:0] == 3'b111, b[2:0] == 3'b111, fake_sum(a, b)};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    logic [33:0] apipe [ADD_LAT+1];
    always_comb apipe[0] = fake_add(add_a, add_b);
    always @(posedge clk) for (int k = 1; k <= ADD_LAT; k++) apipe[k] <= apipe[k-1];
    assign {add_overflow, add_underflow, add_result} = apipe[ADD_LAT];

    // Transaction-level reference: every accepted op sits in sb until popped.
    typedef enum {M_RUN, M_DRAIN, M_HALT} mstate_t;
    typedef struct {
        logic [IDW-1:0] id;
        logic           err;
        logic           ovf;
        logic           unf;
        logic [31:0]    result;
        int             rdy;
    } exp_t;

    exp_t        sb[$];
    mstate_t     m_state;
    int          m_last;
    logic        m_prev_acc;
    logic [31:0] m_add_a, m_add_b;
    logic [2:0]  m_add_rmode;

    int          cycle = 0;
    int          last_pop_cycle = -10;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [NREQ-1:0] obs_ready;
    logic            obs_add_valid, obs_rsp_valid, obs_rsp_err, obs_halted;
    logic [IDW-1:0]  obs_rsp_id;
    logic [31:0]     obs_rsp_result;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_state     = M_RUN;
        m_last      = NREQ - 1;
        m_prev_acc  = 1'b0;
        m_add_a     = '0;
        m_add_b     = '0;
        m_add_rmode = '0;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] a,
                                 input logic [NREQ*32-1:0] b, input logic [NREQ*3-1:0] rm,
                                 input logic rr, input logic fl, input logic rs, input logic r);
        @(posedge clk);
        #1;
        req_valid = v; req_a = a; req_b = b; req_rmode = rm;
        rsp_ready = rr; flush_req = fl; resume = rs; rst = r;
    endtask

    task automatic checkOutput();
        logic [NREQ-1:0] exp_grant;
        logic            exp_rsp_valid, pop;
        int              w, idx;
        logic [2:0]      rm;
        exp_t            e;
        @(negedge clk);
        obs_ready = req_ready; obs_add_valid = add_valid; obs_rsp_valid = rsp_valid;
        obs_rsp_id = rsp_id; obs_rsp_result = rsp_result; obs_rsp_err = rsp_err; obs_halted = halted;
        if (rst) begin
            check_val("rst_req_ready", 32'(req_ready), 0);
            check_val("rst_add_valid", 32'(add_valid), 0);
            check_val("rst_add_a", add_a, 0);
            check_val("rst_add_b", add_b, 0);
            check_val("rst_add_rmode", 32'(add_rmode), 0);
            check_val("rst_rsp_valid", 32'(rsp_valid), 0);
            check_val("rst_rsp_fields", {rsp_result[28:0], rsp_overflow, rsp_underflow, rsp_err}, 0);
            check_val("rst_rsp_id", 32'(rsp_id), 0);
            check_val("rst_halted", 32'(halted), 0);
            model_reset();
        end else begin
            exp_grant = '0;
            w = -1;
            if (m_state == M_RUN && sb.size() < RSP_DEPTH) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (m_last + k) % NREQ;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                if (w >= 0) exp_grant[w] = 1'b1;
            end
            exp_rsp_valid = (sb.size() > 0) && (cycle >= sb[0].rdy);
            check_val("req_ready", 32'(req_ready), 32'(exp_grant));
            check_val("add_valid", 32'(add_valid), 32'(m_prev_acc));
            check_val("add_a", add_a, m_add_a);
            check_val("add_b", add_b, m_add_b);
            check_val("add_rmode", 32'(add_rmode), 32'(m_add_rmode));
            check_val("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            check_val("halted", 32'(halted), 32'(m_state == M_HALT));
            if (exp_rsp_valid) begin
                check_val("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                check_val("rsp_result", rsp_result, sb[0].result);
                check_val("rsp_flags", {29'd0, rsp_overflow, rsp_underflow, rsp_err},
                          {29'd0, sb[0].ovf, sb[0].unf, sb[0].err});
            end
            pop = exp_rsp_valid && rsp_ready;
            if (pop) begin
                void'(sb.pop_front());
                last_pop_cycle = cycle;
            end
            m_prev_acc = (exp_grant != '0);
            if (m_prev_acc) begin
                rm = req_rmode[w*3 +: 3];
                e.id = IDW'(w);
                e.err = (rm > 3'd4);
                {e.ovf, e.unf, e.result} = fake_add(req_a[w*32 +: 32], req_b[w*32 +: 32]);
                e.rdy = cycle + ADD_LAT + 2;
                sb.push_back(e);
                m_last = w;
                m_add_a = req_a[w*32 +: 32];
                m_add_b = req_b[w*32 +: 32];
                m_add_rmode = e.err ? 3'b000 : rm;
            end
            case (m_state)
                M_RUN:   if (flush_req) m_state = M_DRAIN;
                M_DRAIN: if (sb.size() == 0) m_state = M_HALT;
                M_HALT:  if (resume) m_state = M_RUN;
                default: m_state = M_RUN;
            endcase
        end
        cycle++;
    endtask

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [31:0]     a0, b0, a1, b1;
        logic [2:0]      rm0, rm1;
        logic [NREQ-1:0] exp_ready;
        logic            exp_add_valid;
        logic            exp_rsp_valid;
        logic [IDW-1:0]  exp_rsp_id;
        logic [31:0]     exp_rsp_result;
        logic            exp_rsp_err;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          cnt, n_grants;
        logic [1:0]  exp_g;
        logic        halt_seen;

        vecs[0] = '{2'b01, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{2'b10, 32'h0, 32'h0, 32'h40000000, 32'h3F800000, 3'b000, 3'b110, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[4] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 32'h40000000, 1'b0};
        vecs[5] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[6] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 32'h40400000, 1'b1};
        vecs[7] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_rmode = '0;
        rsp_ready = 1'b0; flush_req = 1'b0; resume = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput();
        end

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].valid, {vecs[i].a1, vecs[i].a0}, {vecs[i].b1, vecs[i].b0},
                          {vecs[i].rm1, vecs[i].rm0}, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
            check_val("vec_ready", 32'(obs_ready), 32'(vecs[i].exp_ready));
            check_val("vec_add_valid", 32'(obs_add_valid), 32'(vecs[i].exp_add_valid));
            check_val("vec_rsp_valid", 32'(obs_rsp_valid), 32'(vecs[i].exp_rsp_valid));
            if (vecs[i].exp_rsp_valid) begin
                check_val("vec_rsp_id", 32'(obs_rsp_id), 32'(vecs[i].exp_rsp_id));
                check_val("vec_rsp_result", obs_rsp_result, vecs[i].exp_rsp_result);
                check_val("vec_rsp_err", 32'(obs_rsp_err), 32'(vecs[i].exp_rsp_err));
            end
        end

        $display("[TB] round-robin alternation");
        exp_g = 2'b01;
        n_grants = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
            if (obs_ready != '0) begin
                check_val("rr_alternate", 32'(obs_ready), 32'(exp_g));
                exp_g = {exp_g[0], exp_g[1]};
                if (i < 4) n_grants++;
            end
        end
        check_val("rr_back_to_back", n_grants, 4);
        for (int i = 0; i < 8; i++) begin
            applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
        end

        $display("[TB] credit exhaustion");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput();
            if (obs_ready != '0) cnt++;
        end
        check_val("credit_transfers", cnt, RSP_DEPTH);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
            if (obs_rsp_valid) cnt++;
        end
        check_val("credit_responses", cnt, RSP_DEPTH);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
            if (obs_ready != '0) cnt++;
        end
        check_val("credit_resume", 32'(cnt > 0), 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
        end

        $display("[TB] flush, halt and resume");
        applyStimulus(2'b01, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(2'b10, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus('0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput();
        halt_seen = 1'b0;
        for (int i = 0; i < 20 && !halt_seen; i++) begin
            applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
            if (obs_halted) begin
                halt_seen = 1'b1;
                check_val("halt_timing", cycle - 1, last_pop_cycle + 1);
            end else begin
                check_val("drain_no_ready", 32'(obs_ready), 0);
            end
        end
        check_val("halt_reached", 32'(halt_seen), 1);
        applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput();
        check_val("halt_flush_ignored", 32'(obs_halted), 1);
        applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput();
        applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        check_val("resume_accept", 32'(obs_ready != '0), 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
        end

        $display("[TB] reset with work outstanding");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput();
        end
        applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput();
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus('0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput();
            if (obs_rsp_valid) cnt++;
        end
        check_val("no_stale_rsp", cnt, 0);
        applyStimulus(2'b11, {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()}, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput();
        check_val("post_reset_first", 32'(obs_ready), 32'(2'b01));

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(NREQ'($urandom), {rand_fp(), rand_fp()}, {rand_fp(), rand_fp()},
                          {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))},
                          $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
            checkOutput();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
